cache_lookup_ctrl: RTL

- Direct-mapped, read-only cache lookup and refill controller.
- Sits directly upstream of the cache output register stage. It accepts CPU read requests, checks the tag/valid arrays and, on a miss, refills the line from memory word by word.
- Each request produces exactly one result beat (hit_o, address_o, data_o) with the active-low strobe enable_no asserted for one cycle, which the output register captures.

---
 rtl/cache_lookup_ctrl_if.sv | 50 +++++
 rtl/cache_lookup_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cache_lookup_ctrl_if.sv
// CPU-side and memory-side signals of the cache lookup controller.
// The controller attaches through the slave modport; the requester/memory
// side (CPU, memory model, output register) attaches through master.
interface cache_lookup_ctrl_if;
    // CPU request side
    logic        req_i;
    logic [31:0] address_i;
    logic        flush_i;
    logic        ready_o;
    // Memory refill side
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    // Result beat towards the output register
    logic        enable_no;
    logic        hit_o;
    logic [31:0] address_o;
    logic [31:0] data_o;

    modport slave (
        input  req_i,
        input  address_i,
        input  flush_i,
        output ready_o,
        output mem_req_o,
        output mem_addr_o,
        input  mem_rvalid_i,
        input  mem_rdata_i,
        output enable_no,
        output hit_o,
        output address_o,
        output data_o
    );

    modport master (
        output req_i,
        output address_i,
        output flush_i,
        input  ready_o,
        input  mem_req_o,
        input  mem_addr_o,
        output mem_rvalid_i,
        output mem_rdata_i,
        input  enable_no,
        input  hit_o,
        input  address_o,
        input  data_o
    );
endinterface

// File: rtl/cache_lookup_ctrl.sv
// Direct-mapped, read-only cache lookup and refill controller.
// Accepts one CPU read at a time, checks tag/valid, refills a missing line
// word by word from memory and emits one result beat per request.
//
// Handshakes:
//   CPU:    req_i is taken only in a cycle where ready_o=1 (IDLE); otherwise
//           it is ignored, nothing is queued.
//   Memory: mem_req_o/mem_addr_o are held stable until a cycle with
//           mem_rvalid_i=1, which completes that word. mem_req_o then drops
//           for one cycle before the next word address is requested, so at
//           most one word is ever outstanding. mem_rvalid_i is ignored unless
//           a request is being driven.
//   Result: enable_no is low for exactly one cycle per request; hit_o,
//           address_o and data_o are valid then and hold until the next beat.
module cache_lookup_ctrl #(
    parameter int NUM_LINES      = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    cache_lookup_ctrl_if.slave   bus,
    output logic [1:0]           state_o
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_REFILL  = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic                 gap_q, gap_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic                 hit_q, hit_d;
    logic [31:0]          resp_addr_q, resp_addr_d;
    logic [31:0]          data_q, data_d;

    // Line storage, deliberately not reset; only the valid bits are.
    logic [31:0]          data_arr [NUM_LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0]     tag_arr  [NUM_LINES];

    logic [TAG_W-1:0]     addr_tag;
    logic [IDX_W-1:0]     addr_idx;
    logic [OFF_W-1:0]     addr_off;
    logic                 lookup_hit;
    logic [31:0]          lookup_data;
    logic                 beat_accept;
    logic                 last_beat;
    logic                 data_we;
    logic                 tag_we;

    // Field split of the captured request address and array read-out.
    always_comb begin
        addr_tag    = addr_q[31 -: TAG_W];
        addr_idx    = addr_q[IDX_W+OFF_W+1 : OFF_W+2];
        addr_off    = addr_q[OFF_W+1 : 2];
        lookup_data = data_arr[addr_idx][addr_off];
        lookup_hit  = valid_q[addr_idx] && (tag_arr[addr_idx] == addr_tag);
        beat_accept = (state_q == S_REFILL) && !gap_q && bus.mem_rvalid_i;
        last_beat   = beat_accept && (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
        data_we     = beat_accept;
        tag_we      = last_beat;
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.req_i) state_d = S_LOOKUP;
            S_LOOKUP:  state_d = lookup_hit ? S_RESPOND : S_REFILL;
            S_REFILL:  if (last_beat) state_d = S_RESPOND;
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM-driven outputs; the memory address is only meaningful in REFILL.
    always_comb begin
        bus.ready_o    = (state_q == S_IDLE);
        bus.mem_req_o  = (state_q == S_REFILL) && !gap_q;
        bus.mem_addr_o = (state_q == S_REFILL) ? {addr_tag, addr_idx, cnt_q, 2'b00} : 32'h0;
        bus.enable_no  = (state_q != S_RESPOND);
        bus.hit_o      = hit_q;
        bus.address_o  = resp_addr_q;
        bus.data_o     = data_q;
        state_o        = state_q;
    end

    // Datapath next values: request capture, word counter, valid bits, result.
    always_comb begin
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        gap_d       = 1'b0;
        valid_d     = valid_q;
        hit_d       = hit_q;
        resp_addr_d = resp_addr_q;
        data_d      = data_q;

        if ((state_q == S_IDLE) && bus.req_i) begin
            addr_d = bus.address_i;
        end

        if (state_q == S_LOOKUP) begin
            cnt_d = '0;
            if (lookup_hit) begin
                hit_d       = 1'b1;
                resp_addr_d = addr_q;
                data_d      = lookup_data;
            end
        end

        if (beat_accept) begin
            cnt_d = cnt_q + OFF_W'(1);
            // Drop the request for one cycle between consecutive words.
            gap_d = !last_beat;
        end

        if (last_beat) begin
            valid_d[addr_idx] = 1'b1;
            hit_d             = 1'b0;
            resp_addr_d       = addr_q;
            // The requested word may be the one arriving right now.
            data_d            = (addr_off == cnt_q) ? bus.mem_rdata_i : lookup_data;
        end

        // Flush wins over a refill completing in the same cycle.
        if (bus.flush_i) begin
            valid_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q      <= 32'h0;
            cnt_q       <= '0;
            gap_q       <= 1'b0;
            valid_q     <= '0;
            hit_q       <= 1'b0;
            resp_addr_q <= 32'h0;
            data_q      <= 32'h0;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            valid_q     <= valid_d;
            hit_q       <= hit_d;
            resp_addr_q <= resp_addr_d;
            data_q      <= data_d;
        end
    end

    // Line storage writes: one data word per refill beat, tag on the last one.
    always_ff @(posedge clk_i) begin
        if (data_we) begin
            data_arr[addr_idx][cnt_q] <= bus.mem_rdata_i;
        end
        if (tag_we) begin
            tag_arr[addr_idx] <= addr_tag;
        end
    end

endmodule
